// File: rtl/par_to_ser_pkg.sv
// ---------------------------------------------------------------------------
// par_to_ser_pkg
// Shared types and defaults for the parallel-in serial-out transmitter.
//   par_to_ser_state_t : FSM state encoding (IDLE, SHIFT)
//   PTS_DATA_WIDTH     : default word width in bits
// ---------------------------------------------------------------------------
package par_to_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } par_to_ser_state_t;

    localparam int PTS_DATA_WIDTH = 4;

endpackage : par_to_ser_pkg

// File: rtl/par_to_ser.sv
// ---------------------------------------------------------------------------
// par_to_ser
// Parallel-in serial-out transmitter. Words arrive over a valid/ready
// handshake and leave one bit per clock, with first/last frame markers.
// A one-word holding buffer lets consecutive words stream with no idle bit.
//
// Parameters
//   DATA_WIDTH : word width in bits (>= 2)
//   MSB_FIRST  : 1 = bit DATA_WIDTH-1 leaves first, 0 = bit 0 leaves first
// Ports
//   clk        in   clock, rising edge
//   resetn     in   asynchronous active-low reset
//   din        in   parallel word
//   din_valid  in   din holds a word to send
//   din_ready  out  a word can be accepted this cycle
//   dout       out  serial bit
//   dout_valid out  dout carries a payload bit
//   dout_first out  dout is the first bit of a word
//   dout_last  out  dout is the last bit of a word
// ---------------------------------------------------------------------------
module par_to_ser
    import par_to_ser_pkg::*;
#(
    parameter int DATA_WIDTH = PTS_DATA_WIDTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout,
    output logic                  dout_valid,
    output logic                  dout_first,
    output logic                  dout_last
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    par_to_ser_state_t     r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_buf_full;
    logic [CW-1:0]         r_count;

    par_to_ser_state_t     w_state_next;
    logic [DATA_WIDTH-1:0] w_shreg_next;
    logic [DATA_WIDTH-1:0] w_buf_next;
    logic                  w_buf_full_next;
    logic [CW-1:0]         w_count_next;

    logic                  w_accept;
    logic                  w_last_bit;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_tx_bit;

    // Ready depends only on the buffer flop, never on din_valid.
    assign w_accept   = din_valid && !r_buf_full;
    assign w_last_bit = (r_count == LAST_CNT);
    // Zeros shift in, so a word that drains naturally leaves shreg at 0.
    assign w_shifted  = MSB_FIRST ? {r_shreg[DATA_WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shreg[DATA_WIDTH-1:1]};
    assign w_tx_bit   = MSB_FIRST ? r_shreg[DATA_WIDTH-1] : r_shreg[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_shreg    <= w_shreg_next;
            r_buf      <= w_buf_next;
            r_buf_full <= w_buf_full_next;
            r_count    <= w_count_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_shreg_next    = r_shreg;
        w_buf_next      = r_buf;
        w_buf_full_next = r_buf_full;
        w_count_next    = r_count;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shreg_next = din;
                    w_count_next = '0;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last_bit) begin
                    w_count_next = '0;
                    // The buffered word has priority; when it is present
                    // w_accept is necessarily low, so no word is lost.
                    if (r_buf_full) begin
                        w_shreg_next    = r_buf;
                        w_buf_full_next = 1'b0;
                    end else if (w_accept) begin
                        w_shreg_next = din;
                    end else begin
                        w_shreg_next = w_shifted;
                        w_state_next = IDLE;
                    end
                end else begin
                    w_shreg_next = w_shifted;
                    w_count_next = r_count + CW'(1);
                    if (w_accept) begin
                        w_buf_next      = din;
                        w_buf_full_next = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign din_ready  = !r_buf_full;
    assign dout_valid = (r_state == SHIFT);
    assign dout       = dout_valid && w_tx_bit;
    assign dout_first = dout_valid && (r_count == '0);
    assign dout_last  = dout_valid && w_last_bit;

endmodule : par_to_ser

// File: tb/tb_par_to_ser.sv
module tb_par_to_ser;
    import par_to_ser_pkg::*;

    localparam int W = PTS_DATA_WIDTH;

    logic         clk = 1'b0;
    logic         resetn;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         dout;
    logic         dout_valid;
    logic         dout_first;
    logic         dout_last;

    logic [W-1:0] din_l;
    logic         din_valid_l;
    logic         din_ready_l;
    logic         dout_l;
    logic         dout_valid_l;
    logic         dout_first_l;
    logic         dout_last_l;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    par_to_ser #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_first(dout_first), .dout_last(dout_last)
    );

    par_to_ser #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .resetn(resetn), .din(din_l), .din_valid(din_valid_l),
        .din_ready(din_ready_l), .dout(dout_l), .dout_valid(dout_valid_l),
        .dout_first(dout_first_l), .dout_last(dout_last_l)
    );

    // Monitor + reference deserializer on the MSB-first instance.
    logic         q_bits[$];
    int           q_cyc[$];
    logic [W-1:0] q_words[$];
    logic [W-1:0] mon_acc = '0;
    int           mon_pos = 0;
    int           mon_cyc = 0;
    int           align_err = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            mon_pos = 0;
            mon_acc = '0;
        end else if (dout_valid) begin
            q_bits.push_back(dout);
            q_cyc.push_back(mon_cyc);
            if (dout_first !== (mon_pos == 0) || dout_last !== (mon_pos == W-1))
                align_err++;
            mon_acc = {mon_acc[W-2:0], dout};
            if (mon_pos == W-1) begin
                q_words.push_back(mon_acc);
                mon_pos = 0;
            end else begin
                mon_pos++;
            end
        end
        mon_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_bits.delete();
        q_cyc.delete();
        q_words.delete();
        align_err = 0;
    endtask

    // Present w and hold it until accepted; waits = cycles with ready low.
    task automatic send_word(input logic [W-1:0] w, output int waits);
        bit done;
        done  = 0;
        waits = 0;
        din       = w;
        din_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (din_ready) done = 1;
            else waits++;
            tick();
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_stream(input string tag, input logic [W-1:0] exp_w[$]);
        check({tag, "_nbits"}, q_bits.size(), exp_w.size() * W);
        check({tag, "_nwords"}, q_words.size(), exp_w.size());
        for (int i = 0; i < exp_w.size(); i++)
            if (i < q_words.size())
                check($sformatf("%s_w%0d", tag, i), 32'(q_words[i]), 32'(exp_w[i]));
        if (q_cyc.size() > 0)
            check({tag, "_contig"}, q_cyc[$] - q_cyc[0] + 1, q_cyc.size());
        check({tag, "_align"}, align_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        logic [W-1:0] exp_q[$];
        logic exp_m[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic exp_l[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

        resetn = 1'b0;
        din = '0; din_valid = 1'b0;
        din_l = '0; din_valid_l = 1'b0;
        #12;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_first", dout_first, 0);
        check("rst_last", dout_last, 0);
        check("rst_ready", din_ready, 1);
        check("rst_lsb_ready", din_ready_l, 1);
        #10 resetn = 1'b1;
        tick();

        // Single word MSB first: 1101 -> 1,1,0,1
        clear_mon();
        send_word(4'b1101, waits);
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_dout%0d", i), dout, exp_m[i]);
            check($sformatf("t1_valid%0d", i), dout_valid, 1);
            check($sformatf("t1_first%0d", i), dout_first, i == 0);
            check($sformatf("t1_last%0d", i), dout_last, i == 3);
            tick();
        end
        check("t1_idle_valid", dout_valid, 0);
        check("t1_idle_dout", dout, 0);

        // Back-to-back 0110, 0101
        repeat (2) tick();
        clear_mon();
        send_word(4'b0110, waits);
        send_word(4'b0101, waits);
        din_valid = 1'b0;
        check("t2_ready_c1", din_ready, 0);
        tick();
        tick();
        check("t2_ready_c3", din_ready, 0);
        tick();
        check("t2_ready_c4", din_ready, 1);
        repeat (8) tick();
        exp_q = '{4'b0110, 4'b0101};
        check_stream("t2", exp_q);

        // Backpressure: three words presented continuously
        clear_mon();
        send_word(4'b1001, waits);
        check("t3_w0_waits", waits, 0);
        send_word(4'b0011, waits);
        check("t3_w1_waits", waits, 0);
        send_word(4'b1110, waits);
        check("t3_w2_waits", waits, 3);
        din_valid = 1'b0;
        repeat (14) tick();
        exp_q = '{4'b1001, 4'b0011, 4'b1110};
        check_stream("t3", exp_q);

        // LSB-first instance: 1101 -> 1,0,1,1
        din_l = 4'b1101;
        din_valid_l = 1'b1;
        tick();
        din_valid_l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_dout%0d", i), dout_l, exp_l[i]);
            check($sformatf("t4_first%0d", i), dout_first_l, i == 0);
            check($sformatf("t4_last%0d", i), dout_last_l, i == 3);
            tick();
        end
        check("t4_idle_valid", dout_valid_l, 0);

        // Reset during bit 2 of 1010 with 1111 buffered
        clear_mon();
        send_word(4'b1010, waits);
        send_word(4'b1111, waits);
        din_valid = 1'b0;
        tick();
        check("t5_bit2_dout", dout, 1);
        check("t5_bit2_valid", dout_valid, 1);
        check("t5_buf_ready", din_ready, 0);
        #2 resetn = 1'b0;
        #1;
        check("t5_rst_dout", dout, 0);
        check("t5_rst_valid", dout_valid, 0);
        check("t5_rst_last", dout_last, 0);
        check("t5_rst_ready", din_ready, 1);
        #3 resetn = 1'b1;
        clear_mon();
        repeat (10) tick();
        check("t5_quiet_bits", q_bits.size(), 0);
        send_word(4'b0111, waits);
        din_valid = 1'b0;
        repeat (6) tick();
        exp_q = '{4'b0111};
        check_stream("t5_after", exp_q);

        // Loopback stream of five words
        clear_mon();
        send_word(4'b1101, waits);
        send_word(4'b0110, waits);
        send_word(4'b0101, waits);
        send_word(4'b1100, waits);
        send_word(4'b0111, waits);
        din_valid = 1'b0;
        repeat (24) tick();
        exp_q = '{4'b1101, 4'b0110, 4'b0101, 4'b1100, 4'b0111};
        check_stream("t6", exp_q);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_par_to_ser
